// File: rtl/tulip_prog_pkg.sv
// Shared types and header field positions for the tulip_dsp coefficient loader.
package tulip_prog_pkg;

  typedef enum logic [1:0] {
    TGT_LUT  = 2'd0,
    TGT_FIR  = 2'd1,
    TGT_RVB  = 2'd2,
    TGT_RSVD = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_BAD_TGT  = 2'd1,
    ERR_ZERO_CNT = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STREAM    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_FINISH    = 3'd3,
    S_ERROR     = 3'd4
  } state_e;

  localparam int HDR_TGT_MSB = 31;
  localparam int HDR_TGT_LSB = 30;
  localparam int HDR_CNT_MSB = 15;
  localparam int HDR_CNT_LSB = 0;

endpackage

// File: rtl/prog_out_stage.sv
// Single-entry valid/ready output register; accepts a new word whenever it is
// empty or its current word is being taken in the same cycle.
module prog_out_stage #(
  parameter int G_WIDTH = 24
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [G_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [G_WIDTH-1:0] out_data,
  input  logic               out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Hold the word until the consumer takes it; load on any free slot.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/tulip_prog_loader.sv
// Host-side command loader for the tulip_dsp LUT / FIR / reverb programming
// ports. Optional done-wait watchdog: TULIP_PROG_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | waiting for a header word
// S_STREAM    | forwarding N payload words to the selected target
// S_WAIT_DONE | all words delivered, waiting for the target done flag
// S_FINISH    | one-cycle completion, err_code ok
// S_ERROR     | one-cycle completion with an error code
module tulip_prog_loader
  import tulip_prog_pkg::*;
#(
  parameter int G_LUT_DWIDTH     = 24,
  parameter int G_TAP_DWIDTH     = 16,
  parameter int G_TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [31:0]             host_din,
  input  logic                    host_din_valid,
  output logic                    host_din_ready,
  output logic [G_LUT_DWIDTH-1:0] lut_prog_dout,
  output logic                    lut_prog_dout_valid,
  input  logic                    lut_prog_dout_ready,
  input  logic                    lut_prog_done,
  output logic [G_TAP_DWIDTH-1:0] fir_prog_dout,
  output logic                    fir_prog_dout_valid,
  input  logic                    fir_prog_dout_ready,
  input  logic                    fir_prog_done,
  output logic [G_TAP_DWIDTH-1:0] rvb_prog_dout,
  output logic                    rvb_prog_dout_valid,
  input  logic                    rvb_prog_dout_ready,
  input  logic                    rvb_prog_done,
  output logic                    busy,
  output logic                    cmd_done,
  output logic [1:0]              err_code,
  output logic [15:0]             words_sent
);

  localparam int G_DW = (G_LUT_DWIDTH > G_TAP_DWIDTH) ? G_LUT_DWIDTH : G_TAP_DWIDTH;

  state_e      state_q, state_d;
  tgt_e        tgt_q;
  err_e        err_q, err_d;
  logic [15:0] cnt_q, host_cnt_q;
  logic        clear, tgt_ready, tgt_done, tgt_hs, host_more;
  logic        st_in_valid, st_in_ready, st_out_valid;
  logic [G_DW-1:0] st_out_data;
  tgt_e        hdr_tgt;
  logic [15:0] hdr_cnt;

  assign clear     = !reset_n || !enable;
  assign hdr_tgt   = tgt_e'(host_din[HDR_TGT_MSB:HDR_TGT_LSB]);
  assign hdr_cnt   = host_din[HDR_CNT_MSB:HDR_CNT_LSB];
  assign host_more = host_cnt_q != cnt_q;
  assign tgt_hs    = st_out_valid && tgt_ready;

  // Select the ready/done of the target latched from the header.
  always_comb begin
    tgt_ready = 1'b0;
    tgt_done  = 1'b0;
    case (tgt_q)
      TGT_LUT: begin tgt_ready = lut_prog_dout_ready; tgt_done = lut_prog_done; end
      TGT_FIR: begin tgt_ready = fir_prog_dout_ready; tgt_done = fir_prog_done; end
      TGT_RVB: begin tgt_ready = rvb_prog_dout_ready; tgt_done = rvb_prog_done; end
      default: begin tgt_ready = 1'b0; tgt_done = 1'b0; end
    endcase
  end

  prog_out_stage #(.G_WIDTH(G_DW)) u_out (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (st_in_valid),
    .in_ready  (st_in_ready),
    .in_data   (host_din[G_DW-1:0]),
    .out_valid (st_out_valid),
    .out_data  (st_out_data),
    .out_ready (tgt_ready)
  );

`ifdef TULIP_PROG_TIMEOUT_EN
  localparam int TW = $clog2(G_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;

  // Watchdog down-counter: reloaded outside WAIT_DONE, terminal count at 0.
  always_ff @(posedge clk) begin
    if (clear || state_q != S_WAIT_DONE) tmr_q <= TW'(G_TIMEOUT_CYCLES - 1);
    else if (tmr_q != '0)                tmr_q <= tmr_q - 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (G_TIMEOUT_CYCLES == 0);
`endif

  logic unused_hdr;
  assign unused_hdr = ^host_din[29:24];

  // Next-state, host handshake and error selection.
  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    host_din_ready = 1'b0;
    st_in_valid    = 1'b0;
    if (!clear) begin
      case (state_q)
        S_IDLE: begin
          host_din_ready = 1'b1;
          if (host_din_valid) begin
            if (hdr_tgt == TGT_RSVD) begin
              state_d = S_ERROR;
              err_d   = ERR_BAD_TGT;
            end else if (hdr_cnt == 16'd0) begin
              state_d = S_ERROR;
              err_d   = ERR_ZERO_CNT;
            end else begin
              state_d = S_STREAM;
              err_d   = ERR_OK;
            end
          end
        end
        S_STREAM: begin
          host_din_ready = host_more && st_in_ready;
          st_in_valid    = host_din_valid && host_more;
          if (tgt_hs && words_sent == cnt_q - 16'd1) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tgt_done) state_d = S_FINISH;
`ifdef TULIP_PROG_TIMEOUT_EN
          else if (tmr_q == '0) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
          end
`endif
        end
        S_FINISH, S_ERROR: state_d = S_IDLE;
        default:           state_d = S_IDLE;
      endcase
    end
  end

  // State, command latch and word counters.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= S_IDLE;
      err_q      <= ERR_OK;
      tgt_q      <= TGT_LUT;
      cnt_q      <= '0;
      host_cnt_q <= '0;
      words_sent <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && host_din_valid) begin
        tgt_q      <= hdr_tgt;
        cnt_q      <= hdr_cnt;
        host_cnt_q <= '0;
        words_sent <= '0;
      end
      if (state_q == S_STREAM && host_din_valid && host_din_ready) host_cnt_q <= host_cnt_q + 16'd1;
      if (state_q == S_STREAM && tgt_hs) words_sent <= words_sent + 16'd1;
    end
  end

  assign lut_prog_dout_valid = st_out_valid && tgt_q == TGT_LUT;
  assign fir_prog_dout_valid = st_out_valid && tgt_q == TGT_FIR;
  assign rvb_prog_dout_valid = st_out_valid && tgt_q == TGT_RVB;
  assign lut_prog_dout = (tgt_q == TGT_LUT) ? st_out_data[G_LUT_DWIDTH-1:0] : '0;
  assign fir_prog_dout = (tgt_q == TGT_FIR) ? st_out_data[G_TAP_DWIDTH-1:0] : '0;
  assign rvb_prog_dout = (tgt_q == TGT_RVB) ? st_out_data[G_TAP_DWIDTH-1:0] : '0;

  assign busy     = state_q != S_IDLE;
  assign cmd_done = state_q == S_FINISH || state_q == S_ERROR;
  assign err_code = err_q;

endmodule

// File: tb/tb_tulip_prog_loader.sv
// Randomized bench for tulip_prog_loader against a transaction-level model.
module tb_tulip_prog_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n, enable;
  logic [31:0] host_din;
  logic        host_din_valid, host_din_ready;
  logic [23:0] lut_prog_dout;
  logic [15:0] fir_prog_dout, rvb_prog_dout;
  logic        lut_prog_dout_valid, lut_prog_dout_ready, lut_prog_done;
  logic        fir_prog_dout_valid, fir_prog_dout_ready, fir_prog_done;
  logic        rvb_prog_dout_valid, rvb_prog_dout_ready, rvb_prog_done;
  logic        busy, cmd_done;
  logic [1:0]  err_code;
  logic [15:0] words_sent;

  int checks = 0;
  int errors = 0;
  logic [31:0] pl[$];

  always #5 clk = ~clk;

  tulip_prog_loader #(
    .G_LUT_DWIDTH(24), .G_TAP_DWIDTH(16), .G_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
    .lut_prog_dout(lut_prog_dout), .lut_prog_dout_valid(lut_prog_dout_valid),
    .lut_prog_dout_ready(lut_prog_dout_ready), .lut_prog_done(lut_prog_done),
    .fir_prog_dout(fir_prog_dout), .fir_prog_dout_valid(fir_prog_dout_valid),
    .fir_prog_dout_ready(fir_prog_dout_ready), .fir_prog_done(fir_prog_done),
    .rvb_prog_dout(rvb_prog_dout), .rvb_prog_dout_valid(rvb_prog_dout_valid),
    .rvb_prog_dout_ready(rvb_prog_dout_ready), .rvb_prog_done(rvb_prog_done),
    .busy(busy), .cmd_done(cmd_done), .err_code(err_code), .words_sent(words_sent)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // One command: header, payload from pl, random host/target pacing.
  task automatic run_cmd(input logic [1:0] t, input int n, input int host_pct,
                         input int rdy_pct, input int done_dly, input bit hang);
    int exp_err, exp_words, exp_gap, host_sent, got, cyc, hdr_cyc;
    int first_hs, last_hs, done_cyc, stray, stall_bad;
    bit hdr_done, seen_done, prev_stall, exp_seen, stream, sel_done;
    logic [31:0] prev_data, sel_data, mask;
    logic sel_valid, sel_ready;
    stream    = (t != 2'd3) && (n != 0);
    exp_err   = (t == 2'd3) ? 1 : (n == 0) ? 2 : 0;
    exp_words = stream ? n : 0;
    exp_seen  = 1'b1;
    exp_gap   = done_dly + 1;
    if (hang) begin
`ifdef TULIP_PROG_TIMEOUT_EN
      exp_err = 3;
      exp_gap = TMO + 1;
`else
      exp_seen = 1'b0;
`endif
    end
    mask = (t == 2'd0) ? 32'h00FF_FFFF : 32'h0000_FFFF;
    host_sent = 0; got = 0; cyc = 0; hdr_cyc = 0; first_hs = -1; last_hs = -1;
    done_cyc = 0; stray = 0; stall_bad = 0;
    hdr_done = 0; seen_done = 0; prev_stall = 0; prev_data = '0;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      sel_done = !hang && last_hs >= 0 && cyc >= last_hs + done_dly;
      lut_prog_dout_ready = (t == 2'd0) ? rnd(rdy_pct) : rnd(50);
      fir_prog_dout_ready = (t == 2'd1) ? rnd(rdy_pct) : rnd(50);
      rvb_prog_dout_ready = (t == 2'd2) ? rnd(rdy_pct) : rnd(50);
      lut_prog_done = (t == 2'd0) ? sel_done : rnd(50);
      fir_prog_done = (t == 2'd1) ? sel_done : rnd(50);
      rvb_prog_done = (t == 2'd2) ? sel_done : rnd(50);
      if (!hdr_done) begin
        host_din = {t, 14'($urandom), 16'(n)};
        host_din_valid = 1'b1;
      end else if (stream && host_sent < n) begin
        host_din = pl[host_sent];
        host_din_valid = rnd(host_pct);
      end else begin
        host_din = $urandom;
        host_din_valid = 1'b0;
      end
      #1;
      if (hdr_done && cyc == hdr_cyc + 1) chk("busy_rise", busy, 1);
      case (t)
        2'd0: begin sel_valid = lut_prog_dout_valid; sel_ready = lut_prog_dout_ready; sel_data = 32'(lut_prog_dout); end
        2'd1: begin sel_valid = fir_prog_dout_valid; sel_ready = fir_prog_dout_ready; sel_data = 32'(fir_prog_dout); end
        2'd2: begin sel_valid = rvb_prog_dout_valid; sel_ready = rvb_prog_dout_ready; sel_data = 32'(rvb_prog_dout); end
        default: begin sel_valid = 0; sel_ready = 0; sel_data = '0; end
      endcase
      if (t != 2'd0 && lut_prog_dout_valid) stray++;
      if (t != 2'd1 && fir_prog_dout_valid) stray++;
      if (t != 2'd2 && rvb_prog_dout_valid) stray++;
      if (prev_stall && (!sel_valid || sel_data !== prev_data)) stall_bad++;
      prev_stall = sel_valid && !sel_ready;
      prev_data  = sel_data;
      if (sel_valid && sel_ready) begin
        if (got < n) chk("tgt_data", sel_data, pl[got] & mask);
        if (first_hs < 0) first_hs = cyc;
        got++;
        if (got == n) last_hs = cyc;
      end
      if (host_din_valid && host_din_ready) begin
        if (!hdr_done) begin hdr_done = 1; hdr_cyc = cyc; end
        else host_sent++;
      end
      if (cmd_done) begin
        seen_done = 1;
        done_cyc  = cyc;
        chk("err_code", err_code, exp_err);
        chk("words_sent", words_sent, exp_words);
      end
      cyc++;
    end
    host_din_valid = 1'b0;
    chk("cmd_done_seen", seen_done, exp_seen);
    chk("hs_count", got, exp_words);
    chk("stray_valid", stray, 0);
    chk("stall_hold", stall_bad, 0);
    if (seen_done) begin
      if (stream) chk("done_gap", done_cyc - last_hs, exp_gap);
      else        chk("err_gap", done_cyc - hdr_cyc, 1);
      if (stream && host_pct == 100 && rdy_pct == 100) begin
        chk("latency", first_hs - hdr_cyc, 2);
        chk("throughput", last_hs - first_hs, n - 1);
      end
      @(negedge clk); #1;
      chk("busy_fall", busy, 0);
      chk("done_pulse", cmd_done, 0);
      chk("ready_idle", host_din_ready, 1);
      chk("err_hold", err_code, exp_err);
    end else begin
      chk("busy_hang", busy, 1);
    end
  endtask

  task automatic fill(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back($urandom);
  endtask

  // Abort a FIR command mid-stream with reset_n or enable.
  task automatic abort_mid(input bit use_en);
    @(negedge clk);
    lut_prog_dout_ready = 1; fir_prog_dout_ready = 1; rvb_prog_dout_ready = 1;
    lut_prog_done = 0; fir_prog_done = 0; rvb_prog_done = 0;
    host_din = 32'h4000_000A; host_din_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      host_din = $urandom;
    end
    @(negedge clk);
    host_din_valid = 0;
    #1 chk("abort_midstream_valid", fir_prog_dout_valid, 1);
    if (use_en) enable = 0; else reset_n = 0;
    #1 chk("abort_rdy_low", host_din_ready, 0);
    @(negedge clk);
    reset_n = 1; enable = 1;
    #1;
    chk("abort_fir_valid", fir_prog_dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_done", cmd_done, 0);
    chk("abort_words", words_sent, 0);
  endtask

  initial begin
    reset_n = 0; enable = 1; host_din = '0; host_din_valid = 0;
    lut_prog_dout_ready = 0; fir_prog_dout_ready = 0; rvb_prog_dout_ready = 0;
    lut_prog_done = 0; fir_prog_done = 0; rvb_prog_done = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", host_din_ready, 0);
    chk("rst_valids", {lut_prog_dout_valid, fir_prog_dout_valid, rvb_prog_dout_valid}, 0);
    chk("rst_data", {lut_prog_dout, fir_prog_dout, rvb_prog_dout}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_words", words_sent, 0);
    @(negedge clk);
    reset_n = 1;
    #1 chk("idle_ready", host_din_ready, 1);

    pl = '{32'h11, 32'h22, 32'h33};
    run_cmd(2'd1, 3, 100, 100, 2, 0);

    fill(4);
    run_cmd(2'd0, 4, 100, 50, 1, 0);

    for (int k = 0; k < 12; k++) begin
      int t, n;
      t = $urandom_range(0, 2);
      n = $urandom_range(1, 12);
      fill(n);
      run_cmd(2'(t), n, $urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(1, 4), 0);
    end

    fill(8);
    run_cmd(2'd2, 8, 100, 100, 1, 0);

    pl.delete();
    run_cmd(2'd3, 5, 100, 100, 1, 0);
    run_cmd(2'd2, 0, 100, 100, 1, 0);

    fill(3);
    run_cmd(2'd2, 3, 100, 100, 1, 1);
`ifndef TULIP_PROG_TIMEOUT_EN
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
    #1 chk("hang_reset_busy", busy, 0);
`endif

    abort_mid(0);
    fill(5);
    run_cmd(2'd1, 5, 80, 80, 2, 0);
    abort_mid(1);
    fill(6);
    run_cmd(2'd0, 6, 100, 60, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
